// File: rtl/uart_rx_frame_parser.sv
// Drains the UART RX FIFO, parses SOF/LEN/payload/CHK frames and releases the
// buffered payload on a valid/ready stream only when the XOR checksum matches.
module uart_rx_frame_parser #(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data_out,
  input  logic       rx_empty,
  output logic       rx_read,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       SOF       = 8'hA5;
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_EMIT
  } state_t;

  state_t           state, state_next;
  logic             pending;
  logic [IDX_W-1:0] len_q, idx_q, rd_idx_q;
  logic [7:0]       chk_q;
  logic [TMO_W-1:0] tmo_q;
  logic [7:0]       payload_mem [MAX_LEN];

  logic             in_frame, timeout_hit, handshake, err_set;
  logic [1:0]       err_next;

  always_comb begin
    in_frame    = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    timeout_hit = in_frame && !pending && (tmo_q == TMO_LAST);
    rx_read     = (in_frame || (state == S_IDLE)) && !rx_empty && !pending && !timeout_hit;
    out_valid   = (state == S_EMIT);
    out_data    = out_valid ? payload_mem[rd_idx_q[BUF_AW-1:0]] : 8'h00;
    out_last    = out_valid && (rd_idx_q == (len_q - IDX_ONE));
    handshake   = out_valid && out_ready;
  end

  // A pending fetch means rx_data_out holds a fresh byte this cycle.
  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    err_next   = 2'd0;
    case (state)
      S_IDLE: begin
        if (pending && (rx_data_out == SOF)) state_next = S_LEN;
      end
      S_LEN: begin
        if (pending) begin
          if ((rx_data_out == 8'h00) || (rx_data_out > MAX_LEN_B)) begin
            state_next = S_IDLE;
            err_set    = 1'b1;
            err_next   = 2'd1;
          end else begin
            state_next = S_PAYLOAD;
          end
        end else if (timeout_hit) begin
          state_next = S_IDLE;
          err_set    = 1'b1;
          err_next   = 2'd3;
        end
      end
      S_PAYLOAD: begin
        if (pending) begin
          if ((idx_q + IDX_ONE) == len_q) state_next = S_CHK;
        end else if (timeout_hit) begin
          state_next = S_IDLE;
          err_set    = 1'b1;
          err_next   = 2'd3;
        end
      end
      S_CHK: begin
        if (pending) begin
          if (rx_data_out == chk_q) begin
            state_next = S_EMIT;
          end else begin
            state_next = S_IDLE;
            err_set    = 1'b1;
            err_next   = 2'd2;
          end
        end else if (timeout_hit) begin
          state_next = S_IDLE;
          err_set    = 1'b1;
          err_next   = 2'd3;
        end
      end
      S_EMIT: begin
        if (handshake && out_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // The idle counter is held at zero outside a frame and whenever a byte is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending   <= 1'b0;
      tmo_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rd_idx_q  <= '0;
      chk_q     <= 8'h00;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      pending <= rx_read;
      if (!in_frame || pending) tmo_q <= '0;
      else                      tmo_q <= tmo_q + TMO_ONE;

      case (state)
        S_LEN: begin
          if (pending && (state_next == S_PAYLOAD)) begin
            len_q <= rx_data_out[IDX_W-1:0];
            chk_q <= rx_data_out;
            idx_q <= '0;
          end
        end
        S_PAYLOAD: begin
          if (pending) begin
            chk_q <= chk_q ^ rx_data_out;
            idx_q <= idx_q + IDX_ONE;
          end
        end
        S_CHK: begin
          if (pending) rd_idx_q <= '0;
        end
        S_EMIT: begin
          if (handshake) rd_idx_q <= rd_idx_q + IDX_ONE;
        end
        default: ;
      endcase

      frame_ok  <= handshake && out_last;
      frame_err <= err_set;
      if (err_set) err_code <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == S_PAYLOAD) && pending) payload_mem[idx_q[BUF_AW-1:0]] <= rx_data_out;
  end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed self-checking bench for uart_rx_frame_parser with a simple FIFO model
// and a negedge monitor that records emitted bytes and status pulses.
module tb_uart_rx_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data_out = 8'h00;
  logic       rx_empty;
  logic       rx_read;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  int assert_count = 0;
  int fail_count   = 0;

  uart_rx_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .rx_data_out(rx_data_out), .rx_empty(rx_empty), .rx_read(rx_read),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after the pop strobe.
  logic [7:0] fifo_mem [0:255];
  int push_cnt = 0;
  int pop_cnt = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  assign rx_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_read && (push_cnt != pop_cnt)) begin
      rx_data_out  <= fifo_mem[pop_cnt[7:0]];
      pop_cnt      <= pop_cnt + 1;
      last_pop_cyc <= cyc;
    end
  end

  logic [7:0] got_data [0:63];
  logic       got_last [0:63];
  int got_n = 0, ok_n = 0, err_n = 0, both_n = 0, err_cyc = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready && (got_n < 64)) begin
      got_data[got_n] = out_data;
      got_last[got_n] = out_last;
      got_n++;
    end
    if (frame_ok) ok_n++;
    if (frame_err) begin
      err_n++;
      err_cyc = cyc;
    end
    if (frame_ok && frame_err) both_n++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[push_cnt[7:0]] = bytes[8*(n-1-i) +: 8];
      push_cnt++;
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectBytes(input string tag, input int base, input logic [31:0] bytes,
                             input logic [3:0] last_mask, input int n);
    checkOutput({tag, "_count"}, got_n - base, n);
    if (got_n - base == n) begin
      for (int i = 0; i < n; i++) begin
        checkOutput({tag, "_data"}, got_data[base+i], bytes[8*(n-1-i) +: 8]);
        checkOutput({tag, "_last"}, got_last[base+i], last_mask[n-1-i]);
      end
    end
  endtask

  int b0, o0, e0;

  task automatic snapshot();
    b0 = got_n;
    o0 = ok_n;
    e0 = err_n;
  endtask

  initial begin
    reset = 1'b0;
    out_ready = 1'b1;
    runCycles(3);
    checkOutput("rst_rx_read", rx_read, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_frame_ok", frame_ok, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    checkOutput("rst_err_code", err_code, 0);
    reset = 1'b1;
    runCycles(2);

    $display("[TB] good frame");
    snapshot();
    applyStimulus(64'hA5_03_11_22_33_03, 6);
    runCycles(40);
    expectBytes("t1", b0, 32'h00112233, 4'b0001, 3);
    checkOutput("t1_ok", ok_n - o0, 1);
    checkOutput("t1_err", err_n - e0, 0);
    checkOutput("t1_code", err_code, 0);

    $display("[TB] bad checksum then good frame");
    snapshot();
    applyStimulus(64'hA5_02_AA_BB_00, 5);
    runCycles(30);
    checkOutput("t2_err", err_n - e0, 1);
    checkOutput("t2_code", err_code, 2);
    checkOutput("t2_no_out", got_n - b0, 0);
    snapshot();
    applyStimulus(64'hA5_01_5A_5B, 4);
    runCycles(30);
    expectBytes("t2b", b0, 32'h0000005A, 4'b0001, 1);
    checkOutput("t2b_ok", ok_n - o0, 1);

    $display("[TB] bad length and sync hunt");
    snapshot();
    applyStimulus(64'h00_FF_A5_00, 4);
    runCycles(30);
    checkOutput("t3_err", err_n - e0, 1);
    checkOutput("t3_code", err_code, 1);
    checkOutput("t3_no_out", got_n - b0, 0);
    snapshot();
    applyStimulus(64'hA5_11, 2);
    runCycles(30);
    checkOutput("t3b_err", err_n - e0, 1);
    checkOutput("t3b_code", err_code, 1);
    checkOutput("t3b_ok", ok_n - o0, 0);

    $display("[TB] backpressure");
    snapshot();
    out_ready = 1'b0;
    applyStimulus(64'hA5_03_11_22_33_03, 6);
    applyStimulus(64'hA5_01_5A_5B, 4);
    runCycles(20);
    for (int i = 0; i < 10; i++) begin
      checkOutput("t4_hold", {out_valid, out_last, out_data}, {1'b1, 1'b0, 8'h11});
      checkOutput("t4_no_read", {rx_read, rx_empty}, 2'b00);
      runCycles(1);
    end
    out_ready = 1'b1;
    runCycles(40);
    expectBytes("t4", b0, 32'h1122335A, 4'b0011, 4);
    checkOutput("t4_ok", ok_n - o0, 2);

    $display("[TB] timeout");
    snapshot();
    applyStimulus(64'hA5_02_11, 3);
    runCycles(100);
    checkOutput("t5_err", err_n - e0, 1);
    checkOutput("t5_code", err_code, 3);
    // pop edge -> capture edge (1) + 64 idle edges + edge-count offset (1)
    checkOutput("t5_latency", err_cyc - last_pop_cyc, 66);
    checkOutput("t5_no_out", got_n - b0, 0);
    snapshot();
    applyStimulus(64'hA5_01_5A_5B, 4);
    runCycles(30);
    expectBytes("t5b", b0, 32'h0000005A, 4'b0001, 1);
    checkOutput("t5b_code_held", err_code, 3);

    $display("[TB] reset mid-frame");
    snapshot();
    applyStimulus(64'hA5_02_11, 3);
    runCycles(10);
    reset = 1'b0;
    #1;
    checkOutput("t6_rst_read", rx_read, 0);
    checkOutput("t6_rst_code", err_code, 0);
    runCycles(3);
    reset = 1'b1;
    runCycles(2);
    applyStimulus(64'hA5_01_5A_5B, 4);
    runCycles(30);
    checkOutput("t6_err", err_n - e0, 0);
    expectBytes("t6", b0, 32'h0000005A, 4'b0001, 1);
    checkOutput("t6_ok", ok_n - o0, 1);

    $display("[TB] async reset during emit");
    snapshot();
    out_ready = 1'b0;
    applyStimulus(64'hA5_01_77_76, 4);
    runCycles(20);
    checkOutput("t7_pre", {out_valid, out_last, out_data}, {1'b1, 1'b1, 8'h77});
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t7_async", {out_valid, out_last, out_data}, 10'h000);
    runCycles(2);
    reset = 1'b1;
    out_ready = 1'b1;
    runCycles(10);
    checkOutput("t7_no_out", got_n - b0, 0);
    checkOutput("t7_ok", ok_n - o0, 0);

    checkOutput("ok_err_exclusive", both_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_parser.md
Name: uart_rx_frame_parser

Overview:
Sits directly downstream of the UART RX FIFO and drains bytes from its read port. Parses framed packets of the form SOF (0xA5), LEN, LEN payload bytes, then CHK. Buffers each payload internally. Releases the payload on a valid/ready byte stream only when the checksum is good; otherwise discards the frame and flags an error.

Parameters:
MAX_LEN, 16, maximum legal payload length in bytes (1..255); also the depth of the payload buffer.
TIMEOUT_CYCLES, 4096, idle clk cycles tolerated between bytes inside a frame before the frame is aborted.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx_data_out  input  8  FIFO read data; valid the cycle after rx_read is asserted
rx_empty  input  1  FIFO empty flag
rx_read  output  1  FIFO pop strobe, one cycle per byte
out_data  output  8  payload byte
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts the byte when out_valid && out_ready
out_last  output  1  marks the final payload byte of the frame
frame_ok  output  1  one-cycle pulse on the handshake of the last byte
frame_err  output  1  one-cycle pulse when a frame is discarded
err_code  output  2  0 none, 1 bad LEN, 2 bad CHK, 3 timeout; updated with frame_err and held until the next frame_err

Behaviour:
- Reset (reset=0, asynchronous) clears everything. State=IDLE; rx_read, out_valid, out_last, frame_ok and frame_err are 0; err_code=0; out_data=0; all counters and the checksum are 0. Reset mid-frame discards any partial frame with no error pulse.
- Fetch: rx_read=1 for exactly one cycle when state is IDLE/LEN/PAYLOAD/CHK, rx_empty=0 and no fetch is pending. The byte is captured from rx_data_out on the next cycle, and the pending flag clears. Maximum rate is 1 byte per 2 cycles. rx_read is never asserted in EMIT.
- IDLE: a captured byte of 0xA5 moves to LEN. Any other byte is dropped silently.
- LEN: captured value L.
  - L==0 or L>MAX_LEN: frame_err with err_code=1, then IDLE.
  - Otherwise store L, set chk=L, idx=0, go to PAYLOAD.
- PAYLOAD: each byte is written to buf[idx]; chk ^= byte; idx++. When idx reaches L, go to CHK.
- CHK: compare the captured byte with chk.
  - Equal: go to EMIT with rd_idx=0.
  - Not equal: frame_err with err_code=2, then IDLE. No out_valid is ever asserted for this frame.
- EMIT:
  - out_valid=1 and out_data=buf[rd_idx]. out_last=1 when rd_idx==L-1.
  - out_data, out_valid and out_last stay stable while out_ready=0.
  - On handshake, rd_idx++. On the handshake of the last byte, frame_ok pulses in the following cycle, out_valid drops, and the state returns to IDLE.
- Timeout: a counter runs in LEN/PAYLOAD/CHK only while no fetch is pending; it clears on every byte capture and on entering LEN.
  - When it reaches TIMEOUT_CYCLES: frame_err with err_code=3, then IDLE.
  - A byte captured in the same cycle takes priority over the timeout.
- 0xA5 appearing inside LEN/PAYLOAD/CHK is treated as ordinary data. There is no resync.
- frame_ok and frame_err are never asserted in the same cycle.
- Widths: idx and rd_idx are clog2(MAX_LEN+1) bits wide. chk is 8-bit XOR.

Test Plan:
1. Good frame. FIFO holds A5 03 11 22 33 03, out_ready=1 -> out stream 11,22,33 with out_last only on 33; frame_ok pulses once; frame_err stays 0; err_code stays 0.
2. Bad checksum. FIFO holds A5 02 AA BB 00 (expected CHK 0x13) -> frame_err pulses with err_code=2; out_valid never asserts. A following good frame A5 01 5A 5B outputs 5A with out_last=1.
3. Bad length and sync hunt.
   - FIFO holds 00 FF A5 00 -> FF is dropped silently, then frame_err with err_code=1.
   - A5 11 with MAX_LEN=16 -> err_code=1.
4. Backpressure. Good 3-byte frame with out_ready held low for 10 cycles in EMIT -> out_data stays 11 and stable; rx_read stays 0 even with rx_empty=0; stream completes normally after out_ready rises.
5. Timeout. TIMEOUT_CYCLES=64; FIFO holds A5 02 11, then rx_empty stays 1 -> frame_err with err_code=3 exactly 64 cycles after the 11 is captured; state returns to IDLE.
6. Reset mid-frame. Assert reset after A5 02 11 is captured, then release and send A5 01 5A 5B -> no error pulse; outputs go to 0 immediately (asynchronously); output is only 5A with frame_ok.
